// File: rtl/dmem_pkg.sv
// Shared constants, MMIO register map and FSM encoding for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // MMIO register offsets, decoded on addr[1:0]
    localparam logic [1:0] RXDATA = 2'd0;
    localparam logic [1:0] TXDATA = 2'd1;
    localparam logic [1:0] STATUS = 2'd2;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    // The MMIO window is selected by the single base bit; everything else is RAM.
    function automatic logic is_mmio(input logic [31:0] addr);
        return (addr & MMIO_BASE) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side data memory port: request fields from the master, stall/read data back.
// Latency: none (wires only).
// Backpressure: slave raises stall; master holds the request until stall is low.
interface DataMemory;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] rd;

    modport master (output en, we, addr, wd, input stall, rd);
    modport slave  (input en, we, addr, wd, output stall, rd);
endinterface

// File: rtl/byte_fifo.sv
// Register-based byte FIFO with first-word-fall-through head.
// Latency: a byte pushed at edge N is visible on dout from cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty; callers gate with full/empty.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; simultaneous push/pop keeps count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head never shows stale bytes after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory slave: block RAM plus MMIO byte FIFOs toward the host link.
// Latency: RAM read 2 cycles, RAM write 1 cycle, MMIO 1 cycle plus any FIFO wait.
// Backpressure: stall held while a RAM read is in flight, RX FIFO empty on read, TX FIFO full on write.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_ADDR_W = 15,
    parameter int RX_DEPTH   = 4,
    parameter int TX_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    DataMemory.slave    m_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    state_t                state;
    state_t                state_nxt;
    logic                  mmio;
    logic [1:0]            offset;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  unused_addr_bits;

    logic [31:0]           ram [2**RAM_ADDR_W];
    logic [31:0]           ram_q;
    logic                  ram_we;
    logic                  ram_re;

    logic                  stall;
    logic [31:0]           rd;

    logic                  rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]            rx_head;
    logic                  tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]            tx_head;

    assign mmio             = is_mmio(m_data.addr);
    assign offset           = m_data.addr[1:0];
    assign ram_idx          = m_data.addr[RAM_ADDR_W-1:0];
    assign unused_addr_bits = ^m_data.addr[30:RAM_ADDR_W];

    // Host-side handshakes are forced low while reset is held.
    assign rx_ready = reset & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign tx_valid = reset & ~tx_empty;
    assign tx_data  = tx_valid ? tx_head : 8'h00;
    assign tx_pop   = tx_valid & tx_ready;

    assign m_data.stall = stall;
    assign m_data.rd    = rd;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .din   (m_data.wd[7:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Block RAM with registered read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_idx] <= m_data.wd;
        if (ram_re) ram_q <= ram[ram_idx];
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: only a RAM read leaves IDLE, and RD_WAIT always returns
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_data.en && !mmio && !m_data.we) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall, read data and side-effect strobes, all suppressed in reset
    always_comb begin
        stall   = 1'b0;
        rd      = 32'h0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        rx_pop  = 1'b0;
        tx_push = 1'b0;
        if (reset && m_data.en) begin
            if (state == RD_WAIT) begin
                rd = ram_q;
            end else if (!mmio) begin
                if (m_data.we) begin
                    ram_we = 1'b1;
                end else begin
                    stall  = 1'b1;
                    ram_re = 1'b1;
                end
            end else begin
                case (offset)
                    RXDATA: if (!m_data.we) begin
                        if (rx_empty) begin
                            stall = 1'b1;
                        end else begin
                            rd     = {24'h0, rx_head};
                            rx_pop = 1'b1;
                        end
                    end
                    TXDATA: if (m_data.we) begin
                        if (tx_full) stall   = 1'b1;
                        else         tx_push = 1'b1;
                    end
                    STATUS: if (!m_data.we) rd = {30'h0, tx_full, ~rx_empty};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: master holds requests while stall is high; host randomly toggles rx_valid/tx_ready.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int RAM_ADDR_W = 15;
    localparam int RX_DEPTH   = 4;
    localparam int TX_DEPTH   = 4;

    localparam int K_NONE  = 0;
    localparam int K_RAMRD = 1;
    localparam int K_RAMWR = 2;
    localparam int K_RX    = 3;
    localparam int K_TX    = 4;
    localparam int K_ST    = 5;

    localparam logic [31:0] A_RX = 32'h8000_0000;
    localparam logic [31:0] A_TX = 32'h8000_0001;
    localparam logic [31:0] A_ST = 32'h8000_0002;

    logic       clock;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    DataMemory dm ();

    dmem_responder #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .RX_DEPTH   (RX_DEPTH),
        .TX_DEPTH   (TX_DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .m_data   (dm.slave),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;

    // reference model state
    logic [31:0] ram_m [64];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [7:0]  got_tx [$];
    int          age = 0;

    // last sampled DUT outputs
    logic        obs_stall, obs_rxr, obs_txv, last_done;
    logic [31:0] obs_rd;
    logic [7:0]  obs_txd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int kind(input logic we, input logic [31:0] a);
        if (!a[31]) return we ? K_RAMWR : K_RAMRD;
        case (a[1:0])
            2'd0:    return we ? K_NONE : K_RX;
            2'd1:    return we ? K_TX : K_NONE;
            2'd2:    return we ? K_NONE : K_ST;
            default: return K_NONE;
        endcase
    endfunction

    // One clock cycle: entered and left at posedge+1. Predicts, samples at the falling edge, then advances the model.
    task automatic tick();
        logic        exp_stall, exp_rxr, exp_txv, done, chk_rd, rxv, txr, tfull, rne;
        logic        we;
        logic [31:0] exp_rd, addr, wd;
        logic [7:0]  rxd;
        int          k;
        #4;
        we   = dm.we;
        addr = dm.addr;
        wd   = dm.wd;
        k    = dm.en ? kind(we, addr) : K_NONE;
        exp_rxr   = (rxq.size() < RX_DEPTH);
        exp_txv   = (txq.size() != 0);
        tfull     = (txq.size() == TX_DEPTH);
        rne       = (rxq.size() != 0);
        exp_stall = 1'b0;
        exp_rd    = 32'h0;
        case (k)
            K_RAMRD: begin
                exp_stall = (age == 0);
                exp_rd    = ram_m[addr[5:0]];
            end
            K_RX: begin
                exp_stall = !rne;
                if (rne) exp_rd = {24'h0, rxq[0]};
            end
            K_TX:    exp_stall = tfull;
            K_ST:    exp_rd = {30'h0, tfull, rne};
            default: ;
        endcase
        chk_rd    = !exp_stall && !(dm.en && we);
        obs_stall = dm.stall;
        obs_rd    = dm.rd;
        obs_rxr   = rx_ready;
        obs_txv   = tx_valid;
        obs_txd   = tx_data;
        chk("stall", obs_stall, exp_stall);
        if (chk_rd) chk("rd", obs_rd, exp_rd);
        chk("rx_ready", obs_rxr, exp_rxr);
        chk("tx_valid", obs_txv, exp_txv);
        if (exp_txv) chk("tx_data", obs_txd, txq[0]);
        if (obs_txv && tx_ready) got_tx.push_back(obs_txd);
        done = dm.en && !exp_stall;
        rxv  = rx_valid;
        rxd  = rx_data;
        txr  = tx_ready;
        @(posedge clock);
        if (done && k == K_RAMWR) ram_m[addr[5:0]] = wd;
        if (done && k == K_RX) void'(rxq.pop_front());
        if (rxv && exp_rxr) rxq.push_back(rxd);
        if (exp_txv && txr) void'(txq.pop_front());
        if (done && k == K_TX) txq.push_back(wd[7:0]);
        if (dm.en && !done) age++;
        else                age = 0;
        last_done = done;
        #1;
    endtask

    // Full master transaction: present, wait out the stall, return read data and stall count.
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdv, output int nstall);
        dm.en   = 1'b1;
        dm.we   = we;
        dm.addr = addr;
        dm.wd   = wd;
        nstall  = 0;
        tick();
        while (obs_stall && nstall < 50) begin
            nstall++;
            tick();
        end
        if (obs_stall) chk("req_timeout", obs_stall, 1'b0);
        rdv   = obs_rd;
        dm.en = 1'b0;
    endtask

    initial begin
        logic [31:0] r, a, w;
        int          n, op, req_cycles;
        logic        busy;

        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tx_ready = 1'b1;
        dm.en    = 1'b1;
        dm.we    = 1'b0;
        dm.addr  = 32'h0000_0005;
        dm.wd    = 32'h0;

        // outputs held quiet in reset even with a live read request
        #3;
        chk("rst0_stall", dm.stall, 1'b0);
        chk("rst0_rd", dm.rd, 32'h0);
        chk("rst0_rx_ready", rx_ready, 1'b0);
        chk("rst0_tx_valid", tx_valid, 1'b0);
        chk("rst0_tx_data", tx_data, 8'h00);
        dm.en    = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // RAM write then read, then back-to-back reads
        req(1'b1, 32'h0000_0005, 32'hDEAD_BEEF, r, n);
        chk("wr_nstall", n, 0);
        req(1'b1, 32'h0000_0006, 32'h1234_5678, r, n);
        req(1'b0, 32'h0000_0005, 32'h0, r, n);
        chk("rd_nstall", n, 1);
        chk("rd_data", r, 32'hDEAD_BEEF);
        req(1'b0, 32'h0000_0005, 32'h0, r, n);
        chk("b2b_nstall0", n, 1);
        chk("b2b_data0", r, 32'hDEAD_BEEF);
        req(1'b0, 32'h7FFF_0006, 32'h0, r, n);
        chk("b2b_nstall1", n, 1);
        chk("b2b_data1", r, 32'h1234_5678);

        // RXDATA read while empty, satisfied by a single host byte
        dm.en = 1'b1; dm.we = 1'b0; dm.addr = A_RX;
        tick();
        chk("rx_empty_stall", obs_stall, 1'b1);
        rx_valid = 1'b1; rx_data = 8'h41;
        tick();
        chk("rx_push_cycle_stall", obs_stall, 1'b1);
        rx_valid = 1'b0;
        tick();
        chk("rx_pop_stall", obs_stall, 1'b0);
        chk("rx_pop_rd", obs_rd, 32'h41);
        dm.en = 1'b0;
        req(1'b0, A_ST, 32'h0, r, n);
        chk("rx_empty_after", r, 32'h0);

        // TX fill with host blocked, then drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req(1'b1, A_TX, 32'(i), r, n);
            chk("tx_wr_nstall", n, 0);
        end
        req(1'b0, A_ST, 32'h0, r, n);
        chk("status_tx_full", r, 32'h2);
        dm.en = 1'b1; dm.we = 1'b1; dm.addr = A_TX; dm.wd = 32'h0000_0005;
        got_tx.delete();
        repeat (3) begin
            tick();
            chk("tx5_stall", obs_stall, 1'b1);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && got_tx.size() < 5; i++) begin
            tick();
            if (last_done) dm.en = 1'b0;
        end
        dm.en = 1'b0;
        tx_ready = 1'b0;
        chk("tx_count", got_tx.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got_tx.size()) chk("tx_order", got_tx[i], 32'(i + 1));

        // RX full, pop while the host keeps offering a byte
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h10 + i);
            tick();
        end
        rx_data = 8'h14;
        tick();
        chk("rx_full_ready", obs_rxr, 1'b0);
        dm.en = 1'b1; dm.we = 1'b0; dm.addr = A_RX;
        tick();
        chk("rx_full_pop_stall", obs_stall, 1'b0);
        chk("rx_full_pop_rd", obs_rd, 32'h10);
        dm.en = 1'b0;
        tick();
        chk("rx_ready_rises", obs_rxr, 1'b1);
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, A_RX, 32'h0, r, n);
            chk("rx_order", r, 32'(8'h11 + i));
        end

        // reset asserted while in RD_WAIT
        req(1'b1, 32'h0000_0009, 32'hCAFE_F00D, r, n);
        dm.en = 1'b1; dm.we = 1'b0; dm.addr = 32'h0000_0009;
        tick();
        chk("rdwait_stall", obs_stall, 1'b1);
        reset = 1'b0;
        #2;
        chk("rst_stall", dm.stall, 1'b0);
        chk("rst_rd", dm.rd, 32'h0);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        rxq.delete();
        txq.delete();
        age   = 0;
        dm.en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        req(1'b0, 32'h0000_0009, 32'h0, r, n);
        chk("post_rst_nstall", n, 1);
        chk("post_rst_rd", r, 32'hCAFE_F00D);

        // preload the model-tracked RAM window, then random traffic
        for (int i = 0; i < 64; i++) req(1'b1, 32'(i), $urandom, r, n);
        busy       = 1'b0;
        req_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
            if (!busy) begin
                op    = $urandom_range(0, 6);
                a     = $urandom;
                w     = $urandom;
                dm.en = 1'b1;
                dm.we = 1'b0;
                case (op)
                    0: begin a[31] = 1'b0; a[14:6] = '0; end
                    1: begin a[31] = 1'b0; a[14:6] = '0; dm.we = 1'b1; end
                    2: begin a[31] = 1'b1; a[1:0] = 2'd0; end
                    3: begin a[31] = 1'b1; a[1:0] = 2'd1; dm.we = 1'b1; end
                    4: begin a[31] = 1'b1; a[1:0] = 2'd2; end
                    5: begin a[31] = 1'b1; a[1:0] = 2'd3; dm.we = 1'($urandom_range(0, 1)); end
                    default: dm.en = 1'b0;
                endcase
                dm.addr    = a;
                dm.wd      = w;
                busy       = dm.en;
                req_cycles = 0;
            end
            tick();
            if (busy) begin
                if (last_done) begin
                    busy = 1'b0;
                end else if (++req_cycles > 100) begin
                    chk("rand_req_timeout", obs_stall, 1'b0);
                    busy = 1'b0;
                end
            end
            if (!busy) dm.en = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
